// File: rtl/arty_fpga_core.sv
// arty_fpga_core
//   Board-level core for an Arty 100BASE-T MII link. Oversamples the MII
//   receive interface on the 125 MHz system clock, classifies each received
//   frame as good or bad, counts both, drives the status LEDs and sequences
//   the PHY reset. It can optionally report each frame over a UART.
//
//   Optional feature macro: UART_REPORT_EN
//     defined   : each frame end queues one status byte {err, good_cnt[6:0]}
//                 that is sent 115200 8N1 on uart_txd.
//     undefined : uart_txd is held at 1 and no UART logic is built.
//
// Ports
//   clk, rst                 125 MHz system clock, async active-high reset
//   btn[3:0], sw[3:0]        buttons / switches (btn[0] clears the counters,
//                            sw[0] selects bad/good count on led4..led7)
//   led0..led3 _r/_g/_b      RGB status LEDs
//   led4..led7               low nibble of the selected frame count
//   phy_rx_clk/rxd/rx_dv/rx_er, phy_tx_clk, phy_col, phy_crs
//                            MII inputs, all sampled as data
//   phy_txd, phy_tx_en       MII transmit, held idle
//   phy_reset_n              PHY reset, active low
//   uart_rxd / uart_txd      UART (receive side unused)
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for rx_dv on a sample strobe
//   RX_FRAME | inside a frame, counting nibbles and collecting errors

module arty_fpga_core #(
    parameter         TARGET         = "GENERIC",
    parameter int     PHY_RST_CYCLES = 1250,
    parameter int     ACT_STRETCH    = 16,
    parameter int     UART_DIV       = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [3:0] sw,
    output logic       led0_r,
    output logic       led0_g,
    output logic       led0_b,
    output logic       led1_r,
    output logic       led1_g,
    output logic       led1_b,
    output logic       led2_r,
    output logic       led2_g,
    output logic       led2_b,
    output logic       led3_r,
    output logic       led3_g,
    output logic       led3_b,
    output logic       led4,
    output logic       led5,
    output logic       led6,
    output logic       led7,
    input  logic       phy_rx_clk,
    input  logic [3:0] phy_rxd,
    input  logic       phy_rx_dv,
    input  logic       phy_rx_er,
    input  logic       phy_tx_clk,
    output logic [3:0] phy_txd,
    output logic       phy_tx_en,
    input  logic       phy_col,
    input  logic       phy_crs,
    output logic       phy_reset_n,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int SYNC_W = 19;
    localparam int ACT_W  = (ACT_STRETCH > 0) ? $clog2(ACT_STRETCH + 1) : 1;
    localparam int PHY_W  = (PHY_RST_CYCLES > 0) ? $clog2(PHY_RST_CYCLES + 1) : 1;
    localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_STRETCH);
    localparam logic [PHY_W-1:0] PHY_LOAD = PHY_W'(PHY_RST_CYCLES);

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_FRAME = 1'b1
    } rx_state_t;

    // Every asynchronous input goes through the same two-stage synchronizer,
    // so the MII data and the sampled rx clock stay cycle-aligned.
    logic [SYNC_W-1:0] sync_in;
    logic [SYNC_W-1:0] sync_meta_q, sync_meta_d;
    logic [SYNC_W-1:0] sync_q, sync_d;

    assign sync_in = {btn, sw, phy_rx_clk, phy_rxd, phy_rx_dv, phy_rx_er,
                      phy_tx_clk, phy_col, phy_crs, uart_rxd};

    logic [3:0] btn_s, sw_s, rxd_s;
    logic       rx_clk_s, rx_dv_s, rx_er_s, tx_clk_s, col_s, crs_s, uart_rxd_s;

    assign btn_s      = sync_q[18:15];
    assign sw_s       = sync_q[14:11];
    assign rx_clk_s   = sync_q[10];
    assign rxd_s      = sync_q[9:6];
    assign rx_dv_s    = sync_q[5];
    assign rx_er_s    = sync_q[4];
    assign tx_clk_s   = sync_q[3];
    assign col_s      = sync_q[2];
    assign crs_s      = sync_q[1];
    assign uart_rxd_s = sync_q[0];

    rx_state_t        rx_state_q, rx_state_d;
    logic [15:0]      nib_cnt_q, nib_cnt_d;
    logic             err_q, err_d;
    logic             rx_clk_prev_q, rx_clk_prev_d;
    logic             tx_clk_prev_q, tx_clk_prev_d;
    logic             btn0_prev_q, btn0_prev_d;
    logic [7:0]       good_cnt_q, good_cnt_d;
    logic [7:0]       bad_cnt_q, bad_cnt_d;
    logic             bad_seen_q, bad_seen_d;
    logic             tx_seen_q, tx_seen_d;
    logic [ACT_W-1:0] act_q, act_d;
    logic [PHY_W-1:0] phy_cnt_q, phy_cnt_d;
    logic             phy_ready_q, phy_ready_d;

    logic             strobe;
    logic             clear;
    logic             frame_end;
    logic             frame_err;

    // Rx strobes are suppressed while the PHY is still held in reset, so any
    // traffic seen then never starts a frame.
    assign strobe = rx_clk_s & ~rx_clk_prev_q & phy_ready_q;
    assign clear  = btn_s[0] & ~btn0_prev_q;

    always_comb begin
        sync_meta_d   = sync_in;
        sync_d        = sync_meta_q;
        rx_clk_prev_d = rx_clk_s;
        tx_clk_prev_d = tx_clk_s;
        btn0_prev_d   = btn_s[0];
        rx_state_d    = rx_state_q;
        nib_cnt_d     = nib_cnt_q;
        err_d         = err_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        bad_seen_d    = bad_seen_q;
        tx_seen_d     = tx_seen_q | (tx_clk_s ^ tx_clk_prev_q);
        act_d         = act_q;
        phy_cnt_d     = phy_cnt_q;
        phy_ready_d   = phy_ready_q | (phy_cnt_q <= PHY_W'(1));
        frame_end     = 1'b0;
        frame_err     = 1'b0;

        if (phy_cnt_q != '0) begin
            phy_cnt_d = phy_cnt_q - PHY_W'(1);
        end

        case (rx_state_q)
            RX_IDLE: begin
                // The nibble that opens the frame is counted and checked too.
                if (strobe && rx_dv_s) begin
                    rx_state_d = RX_FRAME;
                    nib_cnt_d  = 16'd1;
                    err_d      = rx_er_s;
                end
            end
            RX_FRAME: begin
                if (strobe) begin
                    if (rx_dv_s) begin
                        if (nib_cnt_q != 16'hFFFF) begin
                            nib_cnt_d = nib_cnt_q + 16'd1;
                        end
                        err_d = err_q | rx_er_s;
                    end else begin
                        rx_state_d = RX_IDLE;
                        frame_end  = 1'b1;
                        // A frame that is not a whole number of bytes is bad.
                        frame_err  = err_q | nib_cnt_q[0];
                    end
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase

        if (frame_end) begin
            act_d = ACT_LOAD;
        end else if (act_q != '0) begin
            act_d = act_q - ACT_W'(1);
        end

        if (clear) begin
            good_cnt_d = 8'd0;
            bad_cnt_d  = 8'd0;
            bad_seen_d = 1'b0;
        end else if (frame_end) begin
            if (frame_err) begin
                bad_cnt_d  = bad_cnt_q + 8'd1;
                bad_seen_d = 1'b1;
            end else begin
                good_cnt_d = good_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q   <= '0;
            sync_q        <= '0;
            rx_clk_prev_q <= 1'b0;
            tx_clk_prev_q <= 1'b0;
            btn0_prev_q   <= 1'b0;
            rx_state_q    <= RX_IDLE;
            nib_cnt_q     <= 16'd0;
            err_q         <= 1'b0;
            good_cnt_q    <= 8'd0;
            bad_cnt_q     <= 8'd0;
            bad_seen_q    <= 1'b0;
            tx_seen_q     <= 1'b0;
            act_q         <= '0;
            phy_cnt_q     <= PHY_LOAD;
            phy_ready_q   <= 1'b0;
        end else begin
            sync_meta_q   <= sync_meta_d;
            sync_q        <= sync_d;
            rx_clk_prev_q <= rx_clk_prev_d;
            tx_clk_prev_q <= tx_clk_prev_d;
            btn0_prev_q   <= btn0_prev_d;
            rx_state_q    <= rx_state_d;
            nib_cnt_q     <= nib_cnt_d;
            err_q         <= err_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            bad_seen_q    <= bad_seen_d;
            tx_seen_q     <= tx_seen_d;
            act_q         <= act_d;
            phy_cnt_q     <= phy_cnt_d;
            phy_ready_q   <= phy_ready_d;
        end
    end

`ifdef UART_REPORT_EN
    localparam int UART_W = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;
    localparam logic [UART_W-1:0] BAUD_LOAD = UART_W'(UART_DIV - 1);

    logic [7:0]        pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [9:0]        shift_q, shift_d;
    logic [3:0]        bits_q, bits_d;
    logic [UART_W-1:0] baud_q, baud_d;

    // The shift register idles at all ones and shifts ones in behind the
    // frame, so its LSB can drive the line directly from a flop.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        shift_d    = shift_q;
        bits_d     = bits_q;
        baud_d     = baud_q;

        if (bits_q != 4'd0) begin
            if (baud_q == '0) begin
                shift_d = {1'b1, shift_q[9:1]};
                bits_d  = bits_q - 4'd1;
                baud_d  = BAUD_LOAD;
            end else begin
                baud_d = baud_q - UART_W'(1);
            end
        end else if (pend_vld_q) begin
            shift_d    = {1'b1, pend_q, 1'b0};
            bits_d     = 4'd10;
            baud_d     = BAUD_LOAD;
            pend_vld_d = 1'b0;
        end

        // Latest frame wins: an unsent byte is simply replaced.
        if (frame_end) begin
            pend_d     = {frame_err, good_cnt_d[6:0]};
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= 8'd0;
            pend_vld_q <= 1'b0;
            shift_q    <= 10'h3FF;
            bits_q     <= 4'd0;
            baud_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            shift_q    <= shift_d;
            bits_q     <= bits_d;
            baud_q     <= baud_d;
        end
    end

    assign uart_txd = shift_q[0];
`else
    assign uart_txd = 1'b1;
`endif

    logic [7:0] disp_cnt;
    assign disp_cnt = sw_s[0] ? bad_cnt_q : good_cnt_q;

    assign led4 = disp_cnt[0];
    assign led5 = disp_cnt[1];
    assign led6 = disp_cnt[2];
    assign led7 = disp_cnt[3];

    assign led0_r = bad_seen_q;
    assign led0_g = (act_q != '0) | (rx_state_q == RX_FRAME);
    assign led0_b = phy_ready_q;
    assign led1_r = col_s;
    assign led1_g = crs_s;
    assign led1_b = tx_seen_q;
    assign {led2_r, led2_g, led2_b} = sw_s[3:1];
    assign {led3_r, led3_g, led3_b} = btn_s[3:1];

    assign phy_txd     = 4'd0;
    assign phy_tx_en   = 1'b0;
    assign phy_reset_n = phy_ready_q;

    // Received data content, the UART receive line and the count high nibble
    // are not needed by any function; TARGET is only a vendor hint.
    logic unused_ok;
    assign unused_ok = ^{rxd_s, uart_rxd_s, disp_cnt[7:4], (TARGET == "GENERIC")};

endmodule

// File: tb/tb_arty_fpga_core.sv
module tb_arty_fpga_core;

    localparam int UART_DIV = 1085;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'd0;
    logic [3:0] sw = 4'd0;
    logic [3:0] phy_rxd = 4'd0;
    logic       phy_rx_clk = 1'b0;
    logic       phy_rx_dv = 1'b0;
    logic       phy_rx_er = 1'b0;
    logic       phy_tx_clk = 1'b0;
    logic       phy_col = 1'b0;
    logic       phy_crs = 1'b0;
    logic       uart_rxd = 1'b1;

    logic led0_r, led0_g, led0_b, led1_r, led1_g, led1_b;
    logic led2_r, led2_g, led2_b, led3_r, led3_g, led3_b;
    logic led4, led5, led6, led7;
    logic [3:0] phy_txd;
    logic       phy_tx_en, phy_reset_n, uart_txd;

    arty_fpga_core dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw),
        .led0_r(led0_r), .led0_g(led0_g), .led0_b(led0_b),
        .led1_r(led1_r), .led1_g(led1_g), .led1_b(led1_b),
        .led2_r(led2_r), .led2_g(led2_g), .led2_b(led2_b),
        .led3_r(led3_r), .led3_g(led3_g), .led3_b(led3_b),
        .led4(led4), .led5(led5), .led6(led6), .led7(led7),
        .phy_rx_clk(phy_rx_clk), .phy_rxd(phy_rxd), .phy_rx_dv(phy_rx_dv),
        .phy_rx_er(phy_rx_er), .phy_tx_clk(phy_tx_clk), .phy_txd(phy_txd),
        .phy_tx_en(phy_tx_en), .phy_col(phy_col), .phy_crs(phy_crs),
        .phy_reset_n(phy_reset_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #4 clk = ~clk;

    logic [15:0] led_all;
    logic [3:0]  led_cnt;
    assign led_all = {led0_r, led0_g, led0_b, led1_r, led1_g, led1_b,
                      led2_r, led2_g, led2_b, led3_r, led3_g, led3_b,
                      led4, led5, led6, led7};
    assign led_cnt = {led7, led6, led5, led4};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame outcome from the frame's length and error flag.
    int m_good = 0;
    int m_bad  = 0;
    int m_red  = 0;

    typedef struct {
        int len;
        int er_pos;
        bit sw0;
        bit clr;
        int exp_cnt;
        int exp_red;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One MII nibble: 5 system clocks, data changes while rx_clk is low.
    task automatic send_nibble(input logic [3:0] d, input logic dv, input logic er);
        phy_rx_clk = 1'b0;
        phy_rxd    = d;
        phy_rx_dv  = dv;
        phy_rx_er  = er;
        tick(3);
        phy_rx_clk = 1'b1;
        tick(2);
    endtask

    task automatic send_frame(input int len, input int er_pos);
        for (int i = 0; i < len; i++) send_nibble(4'(i), 1'b1, i == er_pos);
        repeat (2) send_nibble(4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        btn[0] = 1'b1;
        tick(4);
        btn[0] = 1'b0;
        tick(4);
    endtask

    task automatic model_clear();
        m_good = 0;
        m_bad  = 0;
        m_red  = 0;
    endtask

    task automatic model_frame(input int len, input int er_pos);
        if (er_pos >= 0 || (len % 2) == 1) begin
            m_bad = (m_bad + 1) % 256;
            m_red = 1;
        end else begin
            m_good = (m_good + 1) % 256;
        end
    endtask

    task automatic uart_capture();
        bit got;
        bit rose;
        int rise_at;
        logic [9:0] bits;
        got = 0;
        rose = 0;
        rise_at = 0;
        bits = '0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (uart_txd == 1'b0) got = 1;
        end
        check("uart_start_seen", int'(got), 1);
        if (got) begin
            for (int n = 1; n <= 10 * UART_DIV; n++) begin
                @(negedge clk);
                if (!rose && uart_txd) begin
                    rose = 1;
                    rise_at = n;
                end
                if (n % UART_DIV == UART_DIV / 2) bits[n / UART_DIV] = uart_txd;
            end
            check("uart_bit_time", rise_at, UART_DIV);
            check("uart_frame_bits", int'(bits), 10'b1_0000_0001_0);
            tick(20);
            check("uart_idle_after", int'(uart_txd), 1);
        end
    endtask

    task automatic uart_quiet();
        int lows;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (uart_txd == 1'b0) lows++;
        end
        check("uart_held_high", lows, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_high;
        int got_ready;

        vecs[0] = '{len: 128, er_pos: -1, sw0: 1'b0, clr: 1'b0, exp_cnt: 1, exp_red: 0};
        vecs[1] = '{len: 20,  er_pos: 9,  sw0: 1'b1, clr: 1'b0, exp_cnt: 1, exp_red: 1};
        vecs[2] = '{len: 61,  er_pos: -1, sw0: 1'b0, clr: 1'b0, exp_cnt: 1, exp_red: 1};
        vecs[3] = '{len: 2,   er_pos: -1, sw0: 1'b1, clr: 1'b0, exp_cnt: 2, exp_red: 1};
        vecs[4] = '{len: 6,   er_pos: -1, sw0: 1'b0, clr: 1'b1, exp_cnt: 1, exp_red: 0};
        vecs[5] = '{len: 33,  er_pos: -1, sw0: 1'b1, clr: 1'b0, exp_cnt: 1, exp_red: 1};
        vecs[6] = '{len: 4,   er_pos: 0,  sw0: 1'b1, clr: 1'b0, exp_cnt: 2, exp_red: 1};

        // Reset state and PHY reset sequencing
        tick(5);
        check("rst_leds", int'(led_all), 0);
        check("rst_phy_reset_n", int'(phy_reset_n), 0);
        check("rst_uart_txd", int'(uart_txd), 1);
        check("rst_phy_txd", int'({phy_txd, phy_tx_en}), 0);
        rst = 1'b0;
        first_high = 0;
        for (int k = 1; k <= 1400; k++) begin
            @(posedge clk);
            #1;
            if (phy_reset_n && first_high == 0) first_high = k;
        end
        check("phy_reset_release_cycle", first_high, 1250);
        tick(1);
        check("led0_b_follows_phy", int'(led0_b), 1);
        check("idle_leds", int'(led_all), 16'h2000);

        // First frame from the reset state; UART reports it when built in
        fork
            send_frame(2, -1);
`ifdef UART_REPORT_EN
            uart_capture();
`else
            uart_quiet();
`endif
        join
        check("first_frame_cnt", int'(led_cnt), 1);

        // Activity LED lit while a frame is in progress
        for (int i = 0; i < 10; i++) send_nibble(4'(i), 1'b1, 1'b0);
        check("led0_g_in_frame", int'(led0_g), 1);
        repeat (2) send_nibble(4'd0, 1'b0, 1'b0);
        tick(40);
        do_clear();
        check("clear_cnt", int'(led_cnt), 0);

        // Table-driven directed frames
        for (int v = 0; v < 7; v++) begin
            sw[0] = vecs[v].sw0;
            if (vecs[v].clr) do_clear();
            send_frame(vecs[v].len, vecs[v].er_pos);
            check($sformatf("vec%0d_cnt", v), int'(led_cnt), vecs[v].exp_cnt);
            check($sformatf("vec%0d_led0_r", v), int'(led0_r), vecs[v].exp_red);
            check($sformatf("vec%0d_act_on", v), int'(led0_g), 1);
            tick(30);
            check($sformatf("vec%0d_act_off", v), int'(led0_g), 0);
        end

        // Good-count wrap and clear at count 5
        sw[0] = 1'b0;
        do_clear();
        for (int i = 0; i < 255; i++) send_frame(2, -1);
        check("wrap_255", int'(led_cnt), 15);
        send_frame(2, -1);
        check("wrap_256", int'(led_cnt), 0);
        for (int i = 0; i < 5; i++) send_frame(2, -1);
        check("count_5", int'(led_cnt), 5);
        send_frame(3, -1);
        check("bad_sets_red", int'(led0_r), 1);
        check("good_kept_5", int'(led_cnt), 5);
        do_clear();
        check("clr_good", int'(led_cnt), 0);
        check("clr_red", int'(led0_r), 0);
        sw[0] = 1'b1;
        tick(4);
        check("clr_bad", int'(led_cnt), 0);
        sw[0] = 1'b0;

        // Status pass-through LEDs
        phy_col = 1'b1;
        phy_crs = 1'b0;
        tick(4);
        check("col_crs_a", int'({led1_r, led1_g}), 2);
        phy_col = 1'b0;
        phy_crs = 1'b1;
        tick(4);
        check("col_crs_b", int'({led1_r, led1_g}), 1);
        phy_crs = 1'b0;
        check("tx_seen_before", int'(led1_b), 0);
        for (int i = 0; i < 4; i++) begin
            phy_tx_clk = ~phy_tx_clk;
            tick(3);
        end
        tick(2);
        check("tx_seen_after", int'(led1_b), 1);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] s3;
            logic [2:0] b3;
            s3 = 3'($urandom_range(7, 0));
            b3 = 3'($urandom_range(7, 0));
            sw[3:1]  = s3;
            btn[3:1] = b3;
            tick(4);
            check("sw_leds", int'({led2_r, led2_g, led2_b}), int'(s3));
            check("btn_leds", int'({led3_r, led3_g, led3_b}), int'(b3));
        end
        sw[3:1]  = 3'd0;
        btn[3:1] = 3'd0;

        // Randomized frames against the reference model
        do_clear();
        model_clear();
        for (int i = 0; i < 40; i++) begin
            int len;
            int er;
            len = int'($urandom_range(24, 1));
            er  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
            sw[0] = 1'($urandom_range(1, 0));
            if ($urandom_range(5, 0) == 0) begin
                do_clear();
                model_clear();
            end
            send_frame(len, er);
            model_frame(len, er);
            check("rand_cnt", int'(led_cnt), (sw[0] ? m_bad : m_good) % 16);
            check("rand_led0_r", int'(led0_r), m_red);
        end
        sw[0] = 1'b0;
        tick(40);

        // Reset in the middle of a frame; frames during PHY reset are ignored
        for (int i = 0; i < 5; i++) send_nibble(4'(i), 1'b1, 1'b0);
        rst = 1'b1;
        tick(3);
        check("midrst_leds", int'(led_all), 0);
        check("midrst_uart", int'(uart_txd), 1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_nibble(4'(i), 1'b1, 1'b0);
        check("phyrst_no_frame", int'(led0_g), 0);
        repeat (2) send_nibble(4'd0, 1'b0, 1'b0);
        send_frame(2, -1);
        check("phyrst_ignored", int'(led_cnt), 0);
        check("phyrst_still_low", int'(phy_reset_n), 0);
        got_ready = 0;
        for (int i = 0; i < 1500 && !got_ready; i++) begin
            @(negedge clk);
            if (phy_reset_n) got_ready = 1;
        end
        check("phy_ready_again", got_ready, 1);
        send_frame(4, -1);
        check("post_rst_frame", int'(led_cnt), 1);
        check("post_rst_red", int'(led0_r), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
